// File: rtl/branch_pkg.sv
// Shared types for the branch unit: opcode encodings and the opcode enum.
package branch_pkg;

    localparam logic [1:0] OP_NEXT_ENC = 2'b00;
    localparam logic [1:0] OP_PAGE_ENC = 2'b01;
    localparam logic [1:0] OP_ABS_ENC  = 2'b10;
    localparam logic [1:0] OP_RET_ENC  = 2'b11;

    typedef enum logic [1:0] {
        NEXT = OP_NEXT_ENC,
        PAGE = OP_PAGE_ENC,
        ABS  = OP_ABS_ENC,
        RET  = OP_RET_ENC
    } br_op_t;

endpackage

// File: rtl/return_stack.sv
// Circular return-address stack: push overwrites the oldest entry when full,
// replace swaps the top in place, with sticky overflow/underflow flags.
module return_stack #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         replace,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             top,
    output logic [$clog2(RAS_DEPTH):0]   count,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(RAS_DEPTH);

    logic [WIDTH-1:0] mem_q [RAS_DEPTH];
    logic [PTR_W-1:0] tp_q, tp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             wr_en;
    logic [PTR_W-1:0] wr_idx;
    logic             empty, full;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == FULL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            tp_q  <= tp_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Entry contents are don't-care after reset, so the array has no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wdata;
        end
    end

    always_comb begin
        tp_d   = tp_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        unf_d  = unf_q;
        wr_en  = 1'b0;
        wr_idx = tp_q;
        // Replace on an empty stack degrades to a push plus underflow.
        if (push || (replace && empty)) begin
            tp_d   = tp_q + 1'b1;
            wr_en  = 1'b1;
            wr_idx = tp_q + 1'b1;
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (replace) begin
                unf_d = 1'b1;
            end
        end else if (replace) begin
            wr_en  = 1'b1;
            wr_idx = tp_q;
        end else if (pop) begin
            if (empty) begin
                unf_d = 1'b1;
            end else begin
                tp_d  = tp_q - 1'b1;
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    assign top       = empty ? '0 : mem_q[tp_q];
    assign count     = cnt_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: rtl/branch_unit.sv
// Registered PC with next-PC selection (sequential, page-relative, absolute,
// return) and a hardware return-address stack for nested calls.
module branch_unit
    import branch_pkg::*;
#(
    parameter int unsigned      WIDTH     = 16,
    parameter int unsigned      LO_BITS   = 8,
    parameter int unsigned      OFF_BITS  = 3,
    parameter int unsigned      RAS_DEPTH = 4,
    parameter logic [WIDTH-1:0] RESET_PC  = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         stall,
    input  br_op_t                       op,
    input  logic                         link,
    input  logic                         carry,
    input  logic [WIDTH-1:0]             abs_target,
    input  logic [LO_BITS-1:0]           lo_target,
    input  logic [OFF_BITS-1:0]          page_off,
    output logic [WIDTH-1:0]             pc,
    output logic [WIDTH-1:0]             ras_top,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_overflow,
    output logic                         ras_underflow
);

    localparam int unsigned HI_BITS = WIDTH - LO_BITS;

    logic [WIDTH-1:0]   pc_q, pc_d;
    logic [WIDTH-1:0]   pc_plus1;
    logic [HI_BITS-1:0] pc_hi, off_ext, page_hi;
    logic               ras_empty;
    logic               st_push, st_pop, st_replace;
    logic [WIDTH-1:0]   st_top;
    logic [$clog2(RAS_DEPTH):0] st_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_plus1 = pc_q + 1'b1;
    assign pc_hi    = pc_q[WIDTH-1:LO_BITS];
    // Size-casting a signed operand sign-extends the page offset.
    assign off_ext  = HI_BITS'($signed(page_off));
    assign page_hi  = pc_hi + off_ext + HI_BITS'(carry);
    assign ras_empty = (st_count == '0);

    always_comb begin
        pc_d = pc_q;
        if (!stall) begin
            case (op)
                NEXT:    pc_d = pc_plus1;
                PAGE:    pc_d = {page_hi, lo_target};
                ABS:     pc_d = abs_target;
                RET:     pc_d = ras_empty ? pc_plus1 : st_top;
                default: pc_d = pc_plus1;
            endcase
        end
    end

    // Stack control; a linked RET is a tail-call swap of the top entry.
    always_comb begin
        st_push    = 1'b0;
        st_pop     = 1'b0;
        st_replace = 1'b0;
        if (!stall) begin
            if (op == RET) begin
                st_replace = link;
                st_pop     = !link;
            end else begin
                st_push    = link;
            end
        end
    end

    return_stack #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (st_push),
        .pop       (st_pop),
        .replace   (st_replace),
        .wdata     (pc_plus1),
        .top       (st_top),
        .count     (st_count),
        .overflow  (ras_overflow),
        .underflow (ras_underflow)
    );

    assign pc        = pc_q;
    assign ras_top   = st_top;
    assign ras_count = st_count;

endmodule

// File: tb/tb_branch_unit.sv
// Table-driven bench for branch_unit with a scoreboard queue of expected state.
module tb_branch_unit;
    import branch_pkg::*;

    localparam int unsigned W  = 16;
    localparam int unsigned LO = 8;
    localparam int unsigned OB = 3;
    localparam int unsigned D  = 4;
    localparam int unsigned CW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          stall;
    br_op_t        op;
    logic          link;
    logic          carry;
    logic [W-1:0]  abs_target;
    logic [LO-1:0] lo_target;
    logic [OB-1:0] page_off;
    logic [W-1:0]  pc;
    logic [W-1:0]  ras_top;
    logic [CW-1:0] ras_count;
    logic          ras_overflow;
    logic          ras_underflow;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] top;
        logic [2:0]  cnt;
        logic        ovf;
        logic        unf;
    } exp_t;

    typedef struct {
        logic        stl;
        br_op_t      op;
        logic        lnk;
        logic        cy;
        logic [15:0] abs;
        logic [7:0]  lo;
        logic [2:0]  off;
        exp_t        e;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];

    branch_unit #(
        .WIDTH     (W),
        .LO_BITS   (LO),
        .OFF_BITS  (OB),
        .RAS_DEPTH (D),
        .RESET_PC  (16'h0000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .op            (op),
        .link          (link),
        .carry         (carry),
        .abs_target    (abs_target),
        .lo_target     (lo_target),
        .page_off      (page_off),
        .pc            (pc),
        .ras_top       (ras_top),
        .ras_count     (ras_count),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic void add(input logic stl, input br_op_t o, input logic lnk, input logic cy,
                                input logic [15:0] ab, input logic [7:0] l, input logic [2:0] of,
                                input logic [15:0] epc, input logic [15:0] etop, input logic [2:0] ecnt,
                                input logic eovf, input logic eunf);
        vec_t v;
        v.stl = stl; v.op = o; v.lnk = lnk; v.cy = cy; v.abs = ab; v.lo = l; v.off = of;
        v.e.pc = epc; v.e.top = etop; v.e.cnt = ecnt; v.e.ovf = eovf; v.e.unf = eunf;
        vecs.push_back(v);
    endfunction

    task automatic compare_state(input string tag, input exp_t e);
        chk({tag, ".pc"},  pc, e.pc);
        chk({tag, ".top"}, ras_top, e.top);
        chk({tag, ".cnt"}, 16'(ras_count), 16'(e.cnt));
        chk({tag, ".ovf"}, 16'(ras_overflow), 16'(e.ovf));
        chk({tag, ".unf"}, 16'(ras_underflow), 16'(e.unf));
    endtask

    task automatic apply(input string tag, input vec_t v);
        exp_t e;
        stall      = v.stl;
        op         = v.op;
        link       = v.lnk;
        carry      = v.cy;
        abs_target = v.abs;
        lo_target  = v.lo;
        page_off   = v.off;
        sb.push_back(v.e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty got 0 entries expected 1", tag);
        end else begin
            e = sb.pop_front();
            compare_state(tag, e);
        end
    endtask

    initial begin
        exp_t z;
        vec_t h;

        // stl op  lnk cy abs      lo     off   | pc      top    cnt ovf unf
        add(0, NEXT, 0, 0, 16'h0,    8'h00, 3'd0, 16'h0001, 16'h0000, 3'd0, 0, 0);
        add(0, NEXT, 0, 0, 16'h0,    8'h00, 3'd0, 16'h0002, 16'h0000, 3'd0, 0, 0);
        add(0, NEXT, 0, 0, 16'h0,    8'h00, 3'd0, 16'h0003, 16'h0000, 3'd0, 0, 0);
        add(0, ABS,  0, 0, 16'h12F7, 8'h00, 3'd0, 16'h12F7, 16'h0000, 3'd0, 0, 0);
        add(0, PAGE, 0, 1, 16'h0,    8'h40, 3'd7, 16'h1240, 16'h0000, 3'd0, 0, 0);
        add(0, ABS,  0, 0, 16'hFF00, 8'h00, 3'd0, 16'hFF00, 16'h0000, 3'd0, 0, 0);
        add(0, PAGE, 0, 0, 16'h0,    8'h05, 3'd1, 16'h0005, 16'h0000, 3'd0, 0, 0);
        add(0, PAGE, 0, 0, 16'h0,    8'h33, 3'd7, 16'hFF33, 16'h0000, 3'd0, 0, 0);
        add(0, ABS,  0, 0, 16'hFFFF, 8'h00, 3'd0, 16'hFFFF, 16'h0000, 3'd0, 0, 0);
        add(0, NEXT, 0, 0, 16'h0,    8'h00, 3'd0, 16'h0000, 16'h0000, 3'd0, 0, 0);
        add(0, ABS,  0, 0, 16'h0010, 8'h00, 3'd0, 16'h0010, 16'h0000, 3'd0, 0, 0);
        add(0, ABS,  1, 0, 16'h0200, 8'h00, 3'd0, 16'h0200, 16'h0011, 3'd1, 0, 0);
        add(0, ABS,  1, 0, 16'h0300, 8'h00, 3'd0, 16'h0300, 16'h0201, 3'd2, 0, 0);
        add(0, RET,  0, 0, 16'h0,    8'h00, 3'd0, 16'h0201, 16'h0011, 3'd1, 0, 0);
        add(0, RET,  0, 0, 16'h0,    8'h00, 3'd0, 16'h0011, 16'h0000, 3'd0, 0, 0);
        add(0, ABS,  0, 0, 16'h0010, 8'h00, 3'd0, 16'h0010, 16'h0000, 3'd0, 0, 0);
        add(0, ABS,  1, 0, 16'h0020, 8'h00, 3'd0, 16'h0020, 16'h0011, 3'd1, 0, 0);
        add(0, ABS,  1, 0, 16'h0030, 8'h00, 3'd0, 16'h0030, 16'h0021, 3'd2, 0, 0);
        add(0, ABS,  1, 0, 16'h0040, 8'h00, 3'd0, 16'h0040, 16'h0031, 3'd3, 0, 0);
        add(0, ABS,  1, 0, 16'h0050, 8'h00, 3'd0, 16'h0050, 16'h0041, 3'd4, 0, 0);
        add(0, ABS,  1, 0, 16'h0060, 8'h00, 3'd0, 16'h0060, 16'h0051, 3'd4, 1, 0);
        add(0, RET,  0, 0, 16'h0,    8'h00, 3'd0, 16'h0051, 16'h0041, 3'd3, 1, 0);
        add(0, RET,  0, 0, 16'h0,    8'h00, 3'd0, 16'h0041, 16'h0031, 3'd2, 1, 0);
        add(0, RET,  0, 0, 16'h0,    8'h00, 3'd0, 16'h0031, 16'h0021, 3'd1, 1, 0);
        add(0, RET,  0, 0, 16'h0,    8'h00, 3'd0, 16'h0021, 16'h0000, 3'd0, 1, 0);
        add(0, RET,  0, 0, 16'h0,    8'h00, 3'd0, 16'h0022, 16'h0000, 3'd0, 1, 1);
        add(0, ABS,  0, 0, 16'h00FF, 8'h00, 3'd0, 16'h00FF, 16'h0000, 3'd0, 1, 1);
        add(0, ABS,  1, 0, 16'h0080, 8'h00, 3'd0, 16'h0080, 16'h0100, 3'd1, 1, 1);
        add(0, RET,  1, 0, 16'h0,    8'h00, 3'd0, 16'h0100, 16'h0081, 3'd1, 1, 1);
        add(0, RET,  0, 0, 16'h0,    8'h00, 3'd0, 16'h0081, 16'h0000, 3'd0, 1, 1);
        add(1, RET,  1, 0, 16'h0,    8'h00, 3'd0, 16'h0081, 16'h0000, 3'd0, 1, 1);
        add(0, PAGE, 1, 0, 16'h0,    8'h10, 3'd0, 16'h0010, 16'h0082, 3'd1, 1, 1);
        add(0, NEXT, 1, 0, 16'h0,    8'h00, 3'd0, 16'h0011, 16'h0011, 3'd2, 1, 1);
        add(1, ABS,  1, 0, 16'hBEEF, 8'h00, 3'd0, 16'h0011, 16'h0011, 3'd2, 1, 1);
        add(1, ABS,  1, 0, 16'hBEEF, 8'h00, 3'd0, 16'h0011, 16'h0011, 3'd2, 1, 1);
        add(0, ABS,  1, 0, 16'hBEEF, 8'h00, 3'd0, 16'hBEEF, 16'h0012, 3'd3, 1, 1);

        reset = 1'b1; stall = 1'b0; op = NEXT; link = 1'b0; carry = 1'b0;
        abs_target = '0; lo_target = '0; page_off = '0;
        #12;
        z.pc = 16'h0000; z.top = 16'h0000; z.cnt = 3'd0; z.ovf = 1'b0; z.unf = 1'b0;
        compare_state("reset", z);
        #1 reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            apply($sformatf("v%0d", i), vecs[i]);
        end

        // Asynchronous reset mid-cycle with a populated stack and both flags set.
        #2 reset = 1'b1;
        #1;
        compare_state("midrst", z);
        #1 reset = 1'b0;

        // Tail-call on an empty stack: falls through, pushes, flags underflow.
        h.stl = 0; h.op = RET; h.lnk = 1; h.cy = 0; h.abs = '0; h.lo = '0; h.off = '0;
        h.e.pc = 16'h0001; h.e.top = 16'h0001; h.e.cnt = 3'd1; h.e.ovf = 1'b0; h.e.unf = 1'b1;
        apply("tail_empty", h);
        h.lnk = 0;
        h.e.pc = 16'h0001; h.e.top = 16'h0000; h.e.cnt = 3'd0; h.e.ovf = 1'b0; h.e.unf = 1'b1;
        apply("ret_after", h);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_unit.md
Name: branch_unit

Overview:
- Registered program-counter and branch unit, parametrised in address width, page split and return-address-stack depth.
- Sits between decode and instruction fetch. Each cycle it accepts one branch opcode and the target fields, updates the PC register, and maintains a hardware return-address stack (RAS).
- Replaces the single link register with a stack for nested calls.
- Adds stall and overflow/underflow reporting.

Parameters:
- WIDTH, 16, PC/address width in bits.
- LO_BITS, 8, width of the in-page (low) target field; high part is WIDTH-LO_BITS.
- OFF_BITS, 3, width of the signed page offset for page-relative jumps.
- RAS_DEPTH, 4, return stack entries (power of two, >=2).
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hold all state this cycle; opcode ignored.
- op  in  2  branch_pkg::br_op_t: NEXT=00, PAGE=01, ABS=10, RET=11.
- link  in  1  push PC+1 onto RAS with this op (call).
- carry  in  1  added into high part on PAGE op.
- abs_target  in  WIDTH  absolute target for ABS.
- lo_target  in  LO_BITS  new low part for PAGE.
- page_off  in  OFF_BITS  signed page offset for PAGE.
- pc  out  WIDTH  current PC (registered).
- ras_top  out  WIDTH  current top of stack; 0 when empty.
- ras_count  out  $clog2(RAS_DEPTH)+1  valid entries.
- ras_overflow  out  1  sticky: push occurred while full.
- ras_underflow  out  1  sticky: RET occurred while empty.

Behaviour:
- Reset (async, any time, including mid-sequence):
  - pc=RESET_PC, ras_count=0, ras_top=0, both sticky flags=0.
  - Stack contents are don't-care.
- All updates on the rising clk edge; outputs are registered with one-cycle latency from op to pc.
- stall=1: pc, stack, count and flags all hold; op, link and targets are ignored.
- pc_plus1 = pc+1 modulo 2^WIDTH (wraps all-ones to 0).
- NEXT: pc <= pc_plus1.
- PAGE:
  - hi = pc[WIDTH-1:LO_BITS] + sign_extend(page_off) + carry, modulo 2^(WIDTH-LO_BITS), so the page wraps.
  - pc <= {hi, lo_target}.
- ABS: pc <= abs_target.
- RET with ras_count>0: pc <= top entry; pop (count-1).
- RET with ras_count==0: pc <= pc_plus1; ras_underflow <= 1; count stays 0.
- link=1 with NEXT/PAGE/ABS: push pc_plus1 (the value before update) after computing the target.
  - When full: overwrite the oldest entry (circular), count stays RAS_DEPTH, ras_overflow <= 1.
- link=1 with RET (tail-call swap):
  - Non-empty: pc <= top; top replaced with pc_plus1; count unchanged.
  - Empty: pc <= pc_plus1, push pc_plus1 (count=1), ras_underflow <= 1.
- Sticky flags clear only on reset.
- Stack is a circular buffer of RAS_DEPTH entries with a top pointer. ras_top is the entry at the top pointer, combinational from registered state.

Decomposition:
- branch_pkg: br_op_t enum (NEXT, PAGE, ABS, RET) and localparams for op encodings.
- Sub-module return_stack:
  - Parameters WIDTH and RAS_DEPTH.
  - Ports push, pop, replace, wdata, top, count, overflow, underflow.
  - Owns the circular buffer and pointer logic.
- branch_unit holds the PC register, next-PC mux and page adder.

Test Plan:
- Reset then 3 cycles NEXT (RESET_PC=0) -> pc 1,2,3; ras_count=0; flags 0. Assert reset mid-cycle -> pc=0 immediately.
- pc=0x12F7, PAGE page_off=3'b111 (−1), carry=1, lo_target=0x40 -> pc=0x1240. pc=0xFF00, page_off=+1, carry=0, lo_target=0x05 -> pc=0x0005 (wrap).
- pc=0x0010: ABS link abs=0x0200, then ABS link abs=0x0300, then RET, RET -> pc 0x0200, 0x0300, 0x0201, 0x0011; ras_count 1,2,1,0.
- Push 5 times with RAS_DEPTH=4 (calls from 0x10,0x20,0x30,0x40,0x50) -> ras_overflow=1, count=4. Four RETs -> pc 0x51, 0x41, 0x31, 0x21. A fifth RET -> pc=0x22, ras_underflow=1.
- Stack top=0x0100, pc=0x0080, RET with link=1 -> pc=0x0100, ras_top=0x0081, count unchanged.
- stall=1 for 2 cycles with ABS link abs=0xBEEF -> pc, count and ras_top unchanged. Release -> pc=0xBEEF one cycle later.
